muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width (>=8, even).
REQ-002 SHALL have parameter OPW, default 3, meaning op-code width (RV32M funct3 encoding).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  kill the in-flight operation.
REQ-006 SHALL have port in_valid  input  1  operands and op presented.
REQ-007 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-008 SHALL have port op  input  OPW  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have port src0  input  XLEN  rs1 operand (multiplicand or dividend).
REQ-010 SHALL have port src1  input  XLEN  rs2 operand (multiplier or divisor).
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port res  output  XLEN  result, meaningful only while out_valid=1.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept an operation on a rising edge with in_valid=1, in_ready=1 and flush=0, latching op, src0 and src1 at that edge.
REQ-016 SHALL, on acceptance of a normal operation, take absolute values of signed operands per op and go IDLE->CALC with an iteration counter of 0.
REQ-017 SHALL perform one radix-2 step per cycle in CALC: shift-add for multiply into a 2*XLEN product, restoring shift-subtract for divide.
REQ-018 SHALL go CALC->FIX when the counter reaches XLEN-1, so that CALC lasts exactly XLEN cycles.
REQ-019 SHALL, in FIX, apply sign correction and select the output: low half for MUL, high half for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU; then go FIX->DONE.
REQ-020 SHALL make out_valid rise XLEN+2 cycles after the accepting edge for normal operations.
REQ-021 SHALL sign the remainder like the dividend and negate the quotient when the operand signs differ (signed ops only).
REQ-022 SHALL treat divisor 0 as a special case resolved in the accept cycle: quotient all ones, remainder = src0, next state DONE, latency 1.
REQ-023 SHALL treat signed overflow (src0 = -2^(XLEN-1), src1 = -1, DIV/REM) as a special case with latency 1: quotient = src0, remainder 0.
REQ-024 SHALL hold res and out_valid stable in DONE until out_ready=1, then go DONE->IDLE; no acceptance in that same cycle.
REQ-025 SHALL, on flush=1, go to IDLE at the next edge from any state and discard the result; flush overrides in_valid and out_ready.
REQ-026 SHALL ignore in_valid while in_ready=0; operand changes outside the accept edge have no effect.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, force state IDLE, counter 0, out_valid 0, res 0 and in_ready 1 from the next cycle.
REQ-028 SHALL give rst priority over flush and the handshakes, including a reset asserted mid-CALC or in DONE, with no result emitted afterwards.

Structure
REQ-029 SHALL take the op encodings, state encoding and XLEN default from a shared package (muldiv_pkg) that the decoder also uses.
REQ-030 SHALL use one sub-module, muldiv_step (the combinational per-iteration add/subtract and shift datapath, parametrised by XLEN); the FSM, counter and sign logic stay in muldiv_unit.

Verification
REQ-031 SHALL cover: MUL 7 x -3 with out_ready=1 -> res 0xFFFFFFEB, out_valid on cycle 34 after accept.
REQ-032 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-033 SHALL cover: DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 and REMU 100/7 -> 2.
REQ-034 SHALL cover: DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0; each with 1-cycle latency.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> res stable and in_ready 0 throughout, then IDLE one cycle after out_ready=1.
REQ-036 SHALL cover: flush at CALC cycle 10, and rst in DONE -> IDLE next cycle, no out_valid, and a following DIVU 9/3 returns 3.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op-code encodings, FSM state encoding and small op-decode helpers.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int OPW_DEFAULT  = 3;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic isDivOp(input logic [2:0] op);
      return op[2];
   endfunction

   // rs1 is signed for MULH/MULHSU/DIV/REM, rs2 only for MULH/DIV/REM
   function automatic logic srcASigned(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic srcBSigned(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// acc holds the product high half / partial remainder, lo the multiplier / quotient bits.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            isDiv_i,
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] mulSum;
   logic [XLEN:0] divShift;
   logic [XLEN:0] divDiff;

   // Remainder stays below the divisor, so bit XLEN of the difference is a clean borrow flag
   always_comb begin
      mulSum   = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
      divShift = {acc_i, lo_i[XLEN-1]};
      divDiff  = divShift - {1'b0, opnd_i};
      if (isDiv_i) begin
         if (divDiff[XLEN]) begin
            acc_o = divShift[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b0};
         end else begin
            acc_o = divDiff[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], 1'b1};
         end
      end else begin
         acc_o = mulSum[XLEN:1];
         lo_o  = {mulSum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are processed one bit per cycle,
// then signs are restored in a single fix-up cycle before the result is offered.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int OPW  = OPW_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  op,
   input  logic [XLEN-1:0] src0,
   input  logic [XLEN-1:0] src1,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] res
);

   localparam int CW = $clog2(XLEN);

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
   logic            negA_q, negA_d, negB_q, negB_d;

   logic [2:0]        opIn;
   logic              negA, negB, divZero, divOvf;
   logic [XLEN-1:0]   absA, absB, stepAcc, stepLo, quoFix, remFix, fixRes;
   logic [2*XLEN-1:0] prodFix;

   muldiv_step #(.XLEN(XLEN)) uStep (
      .isDiv_i (isDivOp(op_q)),
      .acc_i   (acc_q),
      .lo_i    (lo_q),
      .opnd_i  (opnd_q),
      .acc_o   (stepAcc),
      .lo_o    (stepLo)
   );

   // Operand decode, early-out detection and sign correction of the finished magnitudes
   always_comb begin
      opIn    = op[2:0];
      negA    = srcASigned(opIn) & src0[XLEN-1];
      negB    = srcBSigned(opIn) & src1[XLEN-1];
      absA    = negA ? -src0 : src0;
      absB    = negB ? -src1 : src1;
      divZero = isDivOp(opIn) && (src1 == '0);
      divOvf  = ((opIn == OP_DIV) || (opIn == OP_REM)) &&
                (src0 == {1'b1, {(XLEN-1){1'b0}}}) && (src1 == '1);
      prodFix = (negA_q ^ negB_q) ? -{acc_q, lo_q} : {acc_q, lo_q};
      quoFix  = (negA_q ^ negB_q) ? -lo_q : lo_q;
      remFix  = negA_q ? -acc_q : acc_q;
      case (op_q)
         OP_MUL:                       fixRes = prodFix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fixRes = prodFix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fixRes = quoFix;
         default:                      fixRes = remFix;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      negA_d  = negA_q;
      negB_d  = negB_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               op_d   = opIn;
               negA_d = negA;
               negB_d = negB;
               if (divZero) begin
                  res_d   = ((opIn == OP_DIV) || (opIn == OP_DIVU)) ? '1 : src0;
                  state_d = S_DONE;
               end else if (divOvf) begin
                  res_d   = (opIn == OP_DIV) ? src0 : '0;
                  state_d = S_DONE;
               end else begin
                  acc_d   = '0;
                  lo_d    = isDivOp(opIn) ? absA : absB;
                  opnd_d  = isDivOp(opIn) ? absB : absA;
                  cnt_d   = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            acc_d = stepAcc;
            lo_d  = stepLo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1)) begin
               cnt_d   = '0;
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            res_d   = fixRes;
            state_d = S_DONE;
         end
         default: begin
            if (out_ready) state_d = S_IDLE;
         end
      endcase
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
         negA_q  <= 1'b0;
         negB_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
         negA_q  <= negA_d;
         negB_q  <= negB_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign res       = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = '0;
   logic [31:0] src0 = '0;
   logic [31:0] src1 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] res;

   int testCount = 0;
   int failCount = 0;

   muldiv_unit #(.XLEN(32), .OPW(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src0      (src0),
      .src1      (src1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: RISC-V M-extension semantics computed with 64-bit integers
   function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      logic [63:0]     p;
      logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (o)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int refLatency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o[2] && b == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one op; returns one time unit after the accepting edge
   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; src0 = a; src1 = b; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 3'($urandom); src0 = $urandom; src1 = $urandom;
   endtask

   task automatic waitValid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int expLat);
      int lat;
      applyStimulus(o, a, b);
      waitValid(lat);
      checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, " res"}, res, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic watchQuiet(input string tag);
      logic saw = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) saw = 1'b1;
      end
      checkOutput(tag, 32'(saw), 32'd0);
   endtask

   initial begin
      int lat;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset res", res, 32'd0);

      runOp("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      runOp("MULHU max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      runOp("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      runOp("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      runOp("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      runOp("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
      runOp("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
      runOp("DIV 5/0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      runOp("REM 5/0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
      runOp("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      runOp("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 9))
            0:       rb = 32'd0;
            1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2:       rb = 32'($urandom_range(1, 15));
            3:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         runOp($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, refModel(ro, ra, rb), refLatency(ro, ra, rb));
      end

      // Consumer stalls for five cycles in DONE
      out_ready = 1'b0;
      applyStimulus(3'd7, 32'd100, 32'd7);
      waitValid(lat);
      checkOutput("stall latency", 32'(lat), 32'd34);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("stall res %0d", i), res, 32'd2);
         checkOutput($sformatf("stall in_ready %0d", i), 32'(in_ready), 32'd0);
         checkOutput($sformatf("stall out_valid %0d", i), 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 3'd5; src0 = 32'd8; src1 = 32'd2;
      @(posedge clk);
      #1;
      checkOutput("release in_ready", 32'(in_ready), 32'd1);
      checkOutput("release out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;

      // Flush in CALC cycle 10
      applyStimulus(3'd0, 32'd123, 32'd456);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush calc in_ready", 32'(in_ready), 32'd1);
      checkOutput("flush calc out_valid", 32'(out_valid), 32'd0);
      watchQuiet("flush calc quiet");
      runOp("DIVU 9/3 after flush", 3'd5, 32'd9, 32'd3, 32'd3, 34);

      // Flush beats in_valid while idle
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; op = 3'd5; src0 = 32'd9; src1 = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      checkOutput("flush idle in_ready", 32'(in_ready), 32'd1);

      // Flush in DONE overrides a stalled consumer
      out_ready = 1'b0;
      applyStimulus(3'd4, 32'd20, 32'd0);
      waitValid(lat);
      checkOutput("flush done latency", 32'(lat), 32'd1);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      out_ready = 1'b1;
      checkOutput("flush done out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush done in_ready", 32'(in_ready), 32'd1);

      // Reset in DONE, with flush and in_valid also asserted
      out_ready = 1'b0;
      applyStimulus(3'd5, 32'd50, 32'd5);
      waitValid(lat);
      checkOutput("rst done latency", 32'(lat), 32'd34);
      @(negedge clk);
      rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checkOutput("rst done in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst done out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst done res", res, 32'd0);
      watchQuiet("rst done quiet");
      runOp("DIVU 9/3 after rst", 3'd5, 32'd9, 32'd3, 32'd3, 34);

      // Reset mid-CALC
      applyStimulus(3'd6, 32'hFFFF_FF00, 32'd7);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst calc in_ready", 32'(in_ready), 32'd1);
      watchQuiet("rst calc quiet");
      runOp("REM after rst", 3'd6, 32'hFFFF_FF00, 32'd7, refModel(3'd6, 32'hFFFF_FF00, 32'd7), 34);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
